// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR coefficient path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   RAM_WIDTH, COEFF_RAM_DEPTH, ORDER   - coefficient geometry
//   clogb2()                            - ceiling log2 for index widths
//   COEFF_IDX_W, COEFF_ADDR_W           - tap index / {bank, index} widths
//   loader_state_e                      - coefficient loader FSM states
//   coeff_wr_t                          - one registered coefficient RAM write
package fir_pkg;

    localparam int RAM_WIDTH       = 8;
    localparam int COEFF_RAM_DEPTH = 8;
    localparam int ORDER           = 8;

    // Smallest w such that 2**w >= depth.
    function automatic int clogb2(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

    localparam int COEFF_IDX_W  = clogb2(COEFF_RAM_DEPTH);
    // One extra bit: the MSB selects the bank in ram_addr, and in counters it
    // lets idx/tap count reach ORDER itself.
    localparam int COEFF_ADDR_W = COEFF_IDX_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        ZFILL,
        WAIT_SWAP
    } loader_state_e;

    typedef struct packed {
        logic                    we;
        logic [COEFF_ADDR_W-1:0] addr;
        logic [RAM_WIDTH-1:0]    din;
    } coeff_wr_t;

endpackage

// File: rtl/fir_coeff_loader.sv
// Loads coefficient frames into the inactive bank of a double-banked RAM and swaps banks on a sample boundary.
// Latency: RAM write 1 cycle after each accepted byte; load_done (ORDER-N)+2 cycles after the last coefficient with strobe high.
// Backpressure: s_ready is low while zero-filling and while waiting for sample_strobe; otherwise every byte is accepted.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last   byte stream: header N, then N coefficients, s_last on the final byte
//   sample_strobe            FIR is between samples, a bank swap is allowed
//   ram_we/ram_addr/ram_din  registered write port, ram_addr = {bank, tap index}, always the inactive bank
//   active_bank, active_taps bank and tap count the FIR must use
//   busy                     loader is mid-frame or waiting to swap
//   load_done, frame_err     single-cycle pulses: bank swapped / frame rejected
module fir_coeff_loader
    import fir_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [RAM_WIDTH-1:0]    s_data,
    input  logic                    s_last,
    input  logic                    sample_strobe,
    output logic                    ram_we,
    output logic [COEFF_ADDR_W-1:0] ram_addr,
    output logic [RAM_WIDTH-1:0]    ram_din,
    output logic                    active_bank,
    output logic [COEFF_ADDR_W-1:0] active_taps,
    output logic                    busy,
    output logic                    load_done,
    output logic                    frame_err
);

    localparam logic [COEFF_ADDR_W-1:0] ORDER_N  = COEFF_ADDR_W'(ORDER);
    localparam logic [COEFF_ADDR_W-1:0] LAST_IDX = COEFF_ADDR_W'(ORDER - 1);
    localparam logic [RAM_WIDTH-1:0]    ORDER_B  = RAM_WIDTH'(ORDER);

    loader_state_e           state;
    loader_state_e           state_nxt;
    logic [COEFF_ADDR_W-1:0] idx;
    logic [COEFF_ADDR_W-1:0] idx_nxt;
    logic [COEFF_ADDR_W-1:0] idx_inc;
    logic [COEFF_ADDR_W-1:0] n_taps;
    logic [COEFF_ADDR_W-1:0] n_taps_nxt;
    logic                    bank;
    logic                    bank_nxt;
    logic [COEFF_ADDR_W-1:0] taps;
    logic [COEFF_ADDR_W-1:0] taps_nxt;
    coeff_wr_t               wr;
    coeff_wr_t               wr_nxt;
    logic                    done_nxt;
    logic                    err_nxt;
    logic                    ready_nxt;
    logic                    xfer;
    logic                    hdr_ok;
    logic                    at_last_coeff;

    assign xfer          = s_valid & s_ready;
    assign idx_inc       = idx + 1'b1;
    assign at_last_coeff = (idx_inc == n_taps);

    // Header is checked at full byte width so 9..255 are rejected, not truncated.
    assign hdr_ok = (s_data != '0) && (s_data <= ORDER_B);

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        n_taps_nxt = n_taps;
        bank_nxt   = bank;
        taps_nxt   = taps;
        wr_nxt     = '0;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (xfer) begin
                    if (hdr_ok && !s_last) begin
                        state_nxt  = LOAD;
                        idx_nxt    = '0;
                        n_taps_nxt = s_data[COEFF_ADDR_W-1:0];
                    end else if (s_last) begin
                        err_nxt = 1'b1;
                    end else begin
                        // Bad header mid-frame: swallow the rest of the frame.
                        state_nxt = DRAIN;
                    end
                end
            end

            LOAD: begin
                if (xfer) begin
                    wr_nxt.we   = 1'b1;
                    wr_nxt.addr = {~bank, idx[COEFF_IDX_W-1:0]};
                    wr_nxt.din  = s_data;
                    idx_nxt     = idx_inc;
                    if (s_last) begin
                        if (at_last_coeff) begin
                            state_nxt = (n_taps == ORDER_N) ? WAIT_SWAP : ZFILL;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else if (at_last_coeff) begin
                        // Frame longer than its header claims.
                        state_nxt = DRAIN;
                    end
                end
            end

            DRAIN: begin
                if (xfer && s_last) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end

            ZFILL: begin
                // Clear stale taps left over from a longer previous set.
                wr_nxt.we   = 1'b1;
                wr_nxt.addr = {~bank, idx[COEFF_IDX_W-1:0]};
                wr_nxt.din  = '0;
                idx_nxt     = idx_inc;
                if (idx == LAST_IDX) begin
                    state_nxt = WAIT_SWAP;
                end
            end

            WAIT_SWAP: begin
                // Swap only between samples so the FIR never mixes two sets.
                if (sample_strobe) begin
                    bank_nxt  = ~bank;
                    taps_nxt  = n_taps;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        ready_nxt = (state_nxt == IDLE) || (state_nxt == LOAD) || (state_nxt == DRAIN);
    end

    // s_ready is registered from the next state so it stays low throughout reset
    // and rises on the first cycle after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            n_taps    <= '0;
            bank      <= 1'b0;
            taps      <= '0;
            wr        <= '0;
            load_done <= 1'b0;
            frame_err <= 1'b0;
            s_ready   <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            n_taps    <= n_taps_nxt;
            bank      <= bank_nxt;
            taps      <= taps_nxt;
            wr        <= wr_nxt;
            load_done <= done_nxt;
            frame_err <= err_nxt;
            s_ready   <= ready_nxt;
        end
    end

    assign ram_we      = wr.we;
    assign ram_addr    = wr.addr;
    assign ram_din     = wr.din;
    assign active_bank = bank;
    assign active_taps = taps;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader: directed frame table, multi-cycle corner sequences, random frames.
// Expected RAM contents, bank/tap state and pulse counts come from a frame-level model.
module tb_fir_coeff_loader;
    import fir_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        s_last = 1'b0;
    logic        sample_strobe = 1'b1;
    logic        ram_we;
    logic [3:0]  ram_addr;
    logic [7:0]  ram_din;
    logic        active_bank;
    logic [3:0]  active_taps;
    logic        busy;
    logic        load_done;
    logic        frame_err;

    always #5 clk = ~clk;

    fir_coeff_loader dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_last        (s_last),
        .sample_strobe (sample_strobe),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_din       (ram_din),
        .active_bank   (active_bank),
        .active_taps   (active_taps),
        .busy          (busy),
        .load_done     (load_done),
        .frame_err     (frame_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Observed side: RAM image built from the DUT write port, pulse counters.
    logic [7:0] shadow [16] = '{default: 8'h00};
    int mon_wr = 0;
    int mon_done = 0;
    int mon_err = 0;
    int bank_viol = 0;

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            shadow[ram_addr] <= ram_din;
            mon_wr <= mon_wr + 1;
            if (ram_addr[3] == active_bank) bank_viol <= bank_viol + 1;
        end
        if (load_done === 1'b1) mon_done <= mon_done + 1;
        if (frame_err === 1'b1) mon_err <= mon_err + 1;
    end

    // Model side.
    logic [7:0] m_ram [16] = '{default: 8'h00};
    int e_wr = 0;
    int e_done = 0;
    int e_err = 0;
    int m_bank = 0;
    int m_taps = 0;
    logic [7:0] pay [16];
    bit strobe_rand = 1'b0;

    typedef struct {
        int hdr;
        int len;
        int base;
        int step;
        int d_err;
        int d_done;
        int d_wr;
        int bank;
        int taps;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (strobe_rand) sample_strobe = ($urandom_range(0, 2) == 0);
    endtask

    task automatic push(input logic [7:0] d, input logic last, input int max_gap);
        int gap;
        int w;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        for (int g = 0; g < gap; g++) begin
            tick();
            s_valid = 1'b0;
        end
        tick();
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        w = 0;
        while (!s_ready && w < 300) begin
            tick();
            w++;
        end
        if (w >= 300) begin
            n_checks++;
            n_errors++;
            $display("FAIL push_timeout: s_ready low for %0d cycles, required a handshake", w);
        end
    endtask

    // Sends header + len bytes of pay[]; lat = cycles from the last transfer to load_done (0 if none).
    task automatic send_frame(input int hdr, input int len, input int max_gap, output int lat);
        int k;
        push(8'(hdr), (len == 0), max_gap);
        for (int i = 0; i < len; i++) push(pay[i], (i == len - 1), max_gap);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        k = 1;
        while (busy && k < 400) begin
            tick();
            k++;
        end
        if (busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", k);
        end
        lat = load_done ? k : 0;
        tick();
        tick();
    endtask

    // Frame-level rules: valid header 1..ORDER with exactly N coefficients and last on byte N.
    task automatic model_frame(input int hdr, input int len);
        int nw;
        int ib;
        ib = (1 - m_bank) * COEFF_RAM_DEPTH;
        if (hdr < 1 || hdr > ORDER || len == 0) begin
            e_err++;
            return;
        end
        nw = (len < hdr) ? len : hdr;
        for (int i = 0; i < nw; i++) m_ram[ib + i] = pay[i];
        e_wr += nw;
        if (len == hdr) begin
            for (int i = hdr; i < ORDER; i++) m_ram[ib + i] = 8'h00;
            e_wr += ORDER - hdr;
            m_bank = 1 - m_bank;
            m_taps = hdr;
            e_done++;
        end else begin
            e_err++;
        end
    endtask

    task automatic check_state(input string tag);
        int mism;
        mism = 0;
        for (int i = 0; i < 16; i++) if (shadow[i] !== m_ram[i]) mism++;
        check({tag, " ram_mismatches"}, mism, 0);
        check({tag, " active_bank"}, int'(active_bank), m_bank);
        check({tag, " active_taps"}, int'(active_taps), m_taps);
        check({tag, " frame_err_count"}, mon_err, e_err);
        check({tag, " load_done_count"}, mon_done, e_done);
        check({tag, " write_count"}, mon_wr, e_wr);
        check({tag, " write_bank_violations"}, bank_viol, 0);
    endtask

    function automatic int out_vec();
        return int'({s_ready, ram_we, ram_addr, ram_din, active_bank, active_taps,
                     busy, load_done, frame_err});
    endfunction

    initial begin
        vec_t vecs[8];
        int lat;
        int b_err;
        int b_done;
        int b_wr;
        int hold_bad;
        logic old_bank;
        int hdr;
        int len;

        vecs[0] = '{8, 8, 'h11, 'h11, 0, 1, 8, 1, 8};
        vecs[1] = '{3, 3, 'h0A, 1,    0, 1, 8, 0, 3};
        vecs[2] = '{2, 2, 'h5A, 1,    0, 1, 8, 1, 2};
        vecs[3] = '{0, 0, 0,    0,    1, 0, 0, 1, 2};
        vecs[4] = '{9, 4, 'h30, 1,    1, 0, 0, 1, 2};
        vecs[5] = '{4, 2, 'h40, 1,    1, 0, 2, 1, 2};
        vecs[6] = '{2, 3, 'h50, 1,    1, 0, 2, 1, 2};
        vecs[7] = '{1, 1, 'h77, 0,    0, 1, 8, 0, 1};

        // Reset state and release.
        tick();
        tick();
        check("reset_outputs", out_vec(), 0);
        rst = 1'b0;
        check("ready_before_release_edge", int'(s_ready), 0);
        tick();
        check("ready_after_release", int'(s_ready), 1);

        // Directed frame table, strobe held high.
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 16; i++) pay[i] = 8'(vecs[v].base + vecs[v].step * i);
            b_err  = mon_err;
            b_done = mon_done;
            b_wr   = mon_wr;
            send_frame(vecs[v].hdr, vecs[v].len, 0, lat);
            model_frame(vecs[v].hdr, vecs[v].len);
            check($sformatf("vec%0d frame_err_pulses", v), mon_err - b_err, vecs[v].d_err);
            check($sformatf("vec%0d load_done_pulses", v), mon_done - b_done, vecs[v].d_done);
            check($sformatf("vec%0d ram_writes", v), mon_wr - b_wr, vecs[v].d_wr);
            check($sformatf("vec%0d active_bank", v), int'(active_bank), vecs[v].bank);
            check($sformatf("vec%0d active_taps", v), int'(active_taps), vecs[v].taps);
            check_state($sformatf("vec%0d", v));
        end

        // Swap latency with strobe tied high.
        for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
        send_frame(5, 5, 0, lat);
        model_frame(5, 5);
        check("latency_n5", lat, ORDER - 5 + 2);
        for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
        send_frame(8, 8, 0, lat);
        model_frame(8, 8);
        check("latency_n8", lat, 2);
        check_state("latency");

        // Swap held off by a low strobe, then a single strobe pulse.
        sample_strobe = 1'b0;
        for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
        push(8'd8, 1'b0, 0);
        for (int i = 0; i < 8; i++) push(pay[i], (i == 7), 0);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        old_bank = active_bank;
        hold_bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (s_ready !== 1'b0 || busy !== 1'b1 || active_bank !== old_bank || load_done !== 1'b0)
                hold_bad++;
        end
        check("swap_hold_violations", hold_bad, 0);
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        check("swap_bank_after_strobe", int'(active_bank), int'(!old_bank));
        check("swap_load_done", int'(load_done), 1);
        tick();
        tick();
        model_frame(8, 8);
        check_state("swap_hold");

        // Random frames with source gaps and random strobe.
        strobe_rand = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 7)       hdr = int'($urandom_range(1, ORDER));
            else if (r == 7) hdr = 0;
            else             hdr = int'($urandom_range(ORDER + 1, 255));
            if ($urandom_range(0, 3) != 0 && hdr >= 1 && hdr <= ORDER) len = hdr;
            else len = int'($urandom_range(0, 10));
            for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
            send_frame(hdr, len, 2, lat);
            model_frame(hdr, len);
            check_state($sformatf("rnd%0d", f));
        end

        // Reset in the middle of a load.
        strobe_rand = 1'b0;
        sample_strobe = 1'b1;
        for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
        push(8'd8, 1'b0, 0);
        for (int i = 0; i < 3; i++) push(pay[i], 1'b0, 0);
        tick();
        s_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) m_ram[(1 - m_bank) * COEFF_RAM_DEPTH + i] = pay[i];
        e_wr += 3;
        b_done = mon_done;
        tick();
        check("midload_reset_outputs", out_vec(), 0);
        tick();
        tick();
        check("midload_reset_no_load_done", mon_done - b_done, 0);
        rst = 1'b0;
        m_bank = 0;
        m_taps = 0;
        tick();
        check("midload_ready_after_release", int'(s_ready), 1);
        check_state("midload_reset");
        for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
        send_frame(8, 8, 1, lat);
        model_frame(8, 8);
        check_state("post_reset_frame");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
